// File: rtl/rgmii_link_ctrl_if.sv
// Signal bundle between the RGMII link/speed controller and its neighbour:
// receive GMII status stream and software force in, speed/link/reset out.
interface rgmii_link_ctrl_if;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;
   logic       force_en;
   logic [1:0] force_speed;
   logic [1:0] speed;
   logic       link_up;
   logic       full_duplex;
   logic       phy_if_rst;
   logic       speed_change;

   modport master (
      output gmii_rxd, gmii_rx_dv, gmii_rx_er, force_en, force_speed,
      input  speed, link_up, full_duplex, phy_if_rst, speed_change
   );

   modport slave (
      input  gmii_rxd, gmii_rx_dv, gmii_rx_er, force_en, force_speed,
      output speed, link_up, full_duplex, phy_if_rst, speed_change
   );
endinterface

// File: rtl/rgmii_link_ctrl.sv
// RGMII link/speed controller: decodes in-band status seen during
// inter-frame gaps, debounces it, commits link/duplex/speed and runs a
// sequenced PHY-interface reset around every speed change.
module rgmii_link_ctrl #(
   parameter int unsigned STABLE_COUNT  = 16,
   parameter int unsigned RESET_CYCLES  = 64,
   parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
   input logic              clk,
   input logic              rst,
   rgmii_link_ctrl_if.slave lc
);
   localparam int unsigned   SW      = $clog2(STABLE_COUNT + 1);
   localparam int unsigned   RW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [SW-1:0] ST_FULL = SW'(STABLE_COUNT);
   localparam logic [RW-1:0] RC_LAST = RW'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_MONITOR,
      ST_HOLD,
      ST_RELEASE
   } state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] rc_cnt, rc_cnt_nxt;
   logic [SW-1:0] st_cnt, st_cnt_nxt;
   logic [3:0]    cand, cand_nxt;          // {link, speed[1:0], duplex}
   logic          cm_link, cm_link_nxt;
   logic          cm_dup, cm_dup_nxt;
   logic [1:0]    cm_speed, cm_speed_nxt;
   logic [1:0]    speed_q, speed_nxt;
   logic          prst_q, prst_nxt;
   logic          chg_q, chg_nxt;

   logic [3:0]    samp;
   logic          samp_valid;
   logic          samp_resv;
   logic [1:0]    eff_speed;
   logic          commit;
   logic          unused_rxd_hi;

   assign samp          = {lc.gmii_rxd[0], lc.gmii_rxd[2:1], lc.gmii_rxd[3]};
   assign samp_valid    = !lc.gmii_rx_dv && !lc.gmii_rx_er;
   assign samp_resv     = (lc.gmii_rxd[2:1] == 2'b11);
   assign eff_speed     = lc.force_en ? lc.force_speed : cm_speed;
   assign commit        = (st_cnt == ST_FULL) && (cand != {cm_link, cm_speed, cm_dup});
   assign unused_rxd_hi = ^lc.gmii_rxd[7:4];

   assign lc.speed        = speed_q;
   assign lc.link_up      = cm_link;
   assign lc.full_duplex  = cm_dup;
   assign lc.phy_if_rst   = prst_q;
   assign lc.speed_change = chg_q;

   // State and datapath registers; async reset restores power-on status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RESET;
         rc_cnt   <= '0;
         st_cnt   <= '0;
         cand     <= '0;
         cm_link  <= 1'b0;
         cm_dup   <= 1'b0;
         cm_speed <= DEFAULT_SPEED;
         speed_q  <= DEFAULT_SPEED;
         prst_q   <= 1'b1;
         chg_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         rc_cnt   <= rc_cnt_nxt;
         st_cnt   <= st_cnt_nxt;
         cand     <= cand_nxt;
         cm_link  <= cm_link_nxt;
         cm_dup   <= cm_dup_nxt;
         cm_speed <= cm_speed_nxt;
         speed_q  <= speed_nxt;
         prst_q   <= prst_nxt;
         chg_q    <= chg_nxt;
      end
   end

   // Next-state: reset sequencing, status debounce/commit, speed-change entry.
   always_comb begin
      state_nxt    = state;
      rc_cnt_nxt   = rc_cnt;
      st_cnt_nxt   = st_cnt;
      cand_nxt     = cand;
      cm_link_nxt  = cm_link;
      cm_dup_nxt   = cm_dup;
      cm_speed_nxt = cm_speed;
      speed_nxt    = speed_q;
      prst_nxt     = prst_q;
      chg_nxt      = 1'b0;

      case (state)
         ST_RESET: begin
            if (rc_cnt == RC_LAST) begin
               state_nxt = ST_MONITOR;
               prst_nxt  = 1'b0;
            end else begin
               rc_cnt_nxt = rc_cnt + RW'(1);
            end
         end

         ST_MONITOR: begin
            // A link-down commit keeps the last good speed.
            if (commit) begin
               cm_link_nxt = cand[3];
               cm_dup_nxt  = cand[0];
               if (cand[3]) begin
                  cm_speed_nxt = cand[2:1];
               end
            end
            if (samp_valid) begin
               if (samp_resv) begin
                  st_cnt_nxt = '0;
               end else if (samp == cand) begin
                  if (st_cnt != ST_FULL) begin
                     st_cnt_nxt = st_cnt + SW'(1);
                  end
               end else begin
                  cand_nxt   = samp;
                  st_cnt_nxt = SW'(1);
               end
            end
            if (eff_speed != speed_q) begin
               state_nxt  = ST_HOLD;
               speed_nxt  = eff_speed;
               prst_nxt   = 1'b1;
               chg_nxt    = 1'b1;
               rc_cnt_nxt = '0;
            end
         end

         ST_HOLD: begin
            if (rc_cnt == RC_LAST) begin
               state_nxt = ST_RELEASE;
               prst_nxt  = 1'b0;
            end else begin
               rc_cnt_nxt = rc_cnt + RW'(1);
            end
         end

         ST_RELEASE: begin
            st_cnt_nxt = '0;
            state_nxt  = ST_MONITOR;
         end

         default: begin
            state_nxt = ST_RESET;
         end
      endcase
   end
endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Self-checking bench for rgmii_link_ctrl: directed scenarios with literal
// expectations, then randomized status/force traffic compared every cycle
// against a history-based behavioural model.
module tb_rgmii_link_ctrl;
   localparam int SC = 16;
   localparam int RC = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   chg_seen = 0;

   rgmii_link_ctrl_if lc ();

   rgmii_link_ctrl #(
      .STABLE_COUNT (SC),
      .RESET_CYCLES (RC),
      .DEFAULT_SPEED(2'b10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .lc (lc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist: valid, non-reserved status nibbles since the last clear (newest last).
   // A commit is due once the newest SC entries are identical.
   logic [3:0] hist[$];
   int         busy_left;
   bit         via_hold, rel;
   logic [1:0] m_speed, m_dec, m_eff;
   logic       m_link, m_dup, m_prst, m_chg;

   function automatic int trail_run();
      int r = 0;
      logic [3:0] last;
      if (hist.size() == 0) return 0;
      last = hist[hist.size()-1];
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] == last) r++;
         else break;
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         busy_left = RC;
         via_hold  = 1'b0;
         rel       = 1'b0;
         m_speed   = 2'b10;
         m_dec     = 2'b10;
         m_link    = 1'b0;
         m_dup     = 1'b0;
         m_prst    = 1'b1;
         m_chg     = 1'b0;
      end else begin
         m_chg = 1'b0;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               m_prst = 1'b0;
               rel    = via_hold;
            end
         end else if (rel) begin
            rel = 1'b0;
            hist.delete();
         end else begin
            logic [3:0] nib;
            m_eff = lc.force_en ? lc.force_speed : m_dec;
            if (trail_run() >= SC) begin
               nib = hist[hist.size()-1];
               if ({nib[0], nib[2:1], nib[3]} != {m_link, m_dec, m_dup}) begin
                  m_link = nib[0];
                  m_dup  = nib[3];
                  if (nib[0]) m_dec = nib[2:1];
               end
            end
            if (m_eff != m_speed) begin
               m_speed   = m_eff;
               m_prst    = 1'b1;
               m_chg     = 1'b1;
               busy_left = RC;
               via_hold  = 1'b1;
            end
            if (!lc.gmii_rx_dv && !lc.gmii_rx_er) begin
               if (lc.gmii_rxd[2:1] == 2'b11) begin
                  hist.delete();
               end else begin
                  hist.push_back(lc.gmii_rxd[3:0]);
                  if (hist.size() > SC) void'(hist.pop_front());
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("speed",        int'(lc.speed),        int'(m_speed));
         chk("link_up",      int'(lc.link_up),      int'(m_link));
         chk("full_duplex",  int'(lc.full_duplex),  int'(m_dup));
         chk("phy_if_rst",   int'(lc.phy_if_rst),   int'(m_prst));
         chk("speed_change", int'(lc.speed_change), int'(m_chg));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] d, input logic dv, input logic er);
      lc.gmii_rxd   = d;
      lc.gmii_rx_dv = dv;
      lc.gmii_rx_er = er;
      @(negedge clk);
      if (lc.speed_change) chg_seen++;
   endtask

   task automatic gap(input int n);
      repeat (n) send(8'h00, 1'b1, 1'b0);
   endtask

   task automatic wait_chg(input string nm, input int lim);
      int k = 0;
      lc.gmii_rx_dv = 1'b1;
      while (lc.speed_change !== 1'b1 && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (lc.speed_change !== 1'b1) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic count_prst(output int n, output int pulses);
      n = 0;
      pulses = 0;
      lc.gmii_rx_dv = 1'b1;
      while (lc.phy_if_rst === 1'b1 && n < 300) begin
         n++;
         if (lc.speed_change) pulses++;
         @(negedge clk);
      end
   endtask

   logic [3:0] pats [9] = '{4'hD, 4'hB, 4'h9, 4'h1, 4'h5, 4'h0, 4'h3, 4'hF, 4'h7};

   initial begin
      int n, p, c0;
      lc.gmii_rxd    = 8'h00;
      lc.gmii_rx_dv  = 1'b1;
      lc.gmii_rx_er  = 1'b0;
      lc.force_en    = 1'b0;
      lc.force_speed = 2'b10;
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_speed", int'(lc.speed), 2);
      chk("rst_phy_if_rst", int'(lc.phy_if_rst), 1);
      rst = 1'b0;

      // Reset sequence length.
      count_prst(n, p);
      chk("reset_len", n, RC);
      chk("reset_speed", int'(lc.speed), 2);
      chk("reset_link", int'(lc.link_up), 0);
      gap(2);

      // Debounce: 15 samples are not enough, the 16th commits one edge later.
      repeat (15) send(8'h0D, 1'b0, 1'b0);
      gap(3);
      chk("deb15_link", int'(lc.link_up), 0);
      send(8'h0D, 1'b0, 1'b0);
      chk("deb16_link_early", int'(lc.link_up), 0);
      gap(1);
      chk("deb16_link", int'(lc.link_up), 1);
      chk("deb16_fd", int'(lc.full_duplex), 1);
      chk("deb16_phy_rst", int'(lc.phy_if_rst), 0);
      gap(3);

      // Decoded speed change to 100M.
      repeat (16) send(8'h0B, 1'b0, 1'b0);
      wait_chg("spd100", 10);
      chk("spd100_speed", int'(lc.speed), 1);
      count_prst(n, p);
      chk("spd100_hold_len", n, RC);
      chk("spd100_pulses", p, 1);
      gap(3);

      // Frame masking: rx_dv cycles between samples do not break the count.
      for (int i = 0; i < 16; i++) begin
         send(8'h09, 1'b0, 1'b0);
         send(8'h5A, 1'b1, 1'b0);
      end
      wait_chg("mask", 10);
      chk("mask_speed", int'(lc.speed), 0);
      count_prst(n, p);
      chk("mask_hold_len", n, RC);
      gap(3);
      chk("mask_link", int'(lc.link_up), 1);

      // Reserved sample clears the count: 10 + reserved + 15 does not commit.
      c0 = chg_seen;
      repeat (10) send(8'h0D, 1'b0, 1'b0);
      send(8'h07, 1'b0, 1'b0);
      repeat (15) send(8'h0D, 1'b0, 1'b0);
      gap(5);
      chk("resv_no_change", chg_seen - c0, 0);
      chk("resv_speed", int'(lc.speed), 0);
      send(8'h0D, 1'b0, 1'b0);
      wait_chg("resv16", 10);
      chk("resv16_speed", int'(lc.speed), 2);
      count_prst(n, p);
      gap(3);

      // Force to 10M, then re-force during HOLD: a second sequence follows.
      lc.force_en    = 1'b1;
      lc.force_speed = 2'b00;
      wait_chg("force0", 5);
      chk("force0_speed", int'(lc.speed), 0);
      repeat (10) @(negedge clk);
      lc.force_speed = 2'b01;
      count_prst(n, p);
      chk("force0_hold_speed", int'(lc.speed), 0);
      wait_chg("force1", 10);
      chk("force1_speed", int'(lc.speed), 1);
      count_prst(n, p);
      chk("force1_hold_len", n, RC);
      gap(3);

      // Async reset at HOLD cycle 10.
      lc.force_speed = 2'b10;
      wait_chg("force2", 5);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_speed", int'(lc.speed), 2);
      chk("arst_link", int'(lc.link_up), 0);
      chk("arst_fd", int'(lc.full_duplex), 0);
      chk("arst_phy_rst", int'(lc.phy_if_rst), 1);
      chk("arst_chg", int'(lc.speed_change), 0);
      @(negedge clk);
      rst = 1'b0;
      count_prst(n, p);
      chk("arst_reset_len", n, RC);
      lc.force_en = 1'b0;
      gap(3);

      // Randomized traffic, checked every cycle by the model.
      repeat (150) begin
         logic [3:0] v;
         int len;
         v   = pats[$urandom_range(0, 8)];
         len = $urandom_range(1, 40);
         if ($urandom_range(0, 9) == 0) begin
            lc.force_en    = ~lc.force_en;
            lc.force_speed = 2'($urandom_range(0, 2));
         end
         repeat (len) begin
            send({4'($urandom_range(0, 15)), v},
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 19) == 0));
         end
      end
      gap(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
